// File: rtl/channel_frame_sender.sv
// Dual-rail 4-phase RTZ sender for channel-control frames (preamble, C, D, P).
// Ports: clk, reset (sync, active-high), go/ch1/ch2/up/down command request,
//   ack (async 4-phase ack), bit0_out/bit1_out rails, busy, done and err pulses.
module channel_frame_sender #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter logic [1:0]  PREAMBLE    = 2'b10
) (
  input  logic clk,
  input  logic reset,
  input  logic go,
  input  logic ch1,
  input  logic ch2,
  input  logic up,
  input  logic down,
  input  logic ack,
  output logic bit0_out,
  output logic bit1_out,
  output logic busy,
  output logic done,
  output logic err
);

  localparam int unsigned CW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [2:0] IDX_LAST = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_RTZ,
    S_ABORT
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;
  logic [4:0]    frame_q, frame_d;
  logic [2:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic bit0_q, bit0_d;
  logic bit1_q, bit1_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic err_q, err_d;

  logic       ack_s;
  logic       cmd_ok;
  logic [4:0] cmd_frame;
  logic [2:0] idx_nxt;
  logic       bit_nxt;
  logic       cnt_end;

  always_comb begin
    ack_sync_d = '0;
    ack_sync_d[0] = ack;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      ack_sync_d[i] = ack_sync_q[i-1];
    end
  end

  assign ack_s = ack_sync_q[SYNC_STAGES-1];

  // Frame is stored transmit-order: bit 0 goes out first.
  assign cmd_ok    = (ch1 ^ ch2) & (up ^ down);
  assign cmd_frame = {ch2 ^ up, up, ch2, PREAMBLE[0], PREAMBLE[1]};

  assign idx_nxt = idx_q + 3'd1;
  assign bit_nxt = frame_q[idx_nxt];
  assign cnt_end = (cnt_q == CNT_LAST);

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    bit0_d  = 1'b0;
    bit1_d  = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        idx_d  = '0;
        cnt_d  = '0;
        if (go) begin
          if (cmd_ok) begin
            frame_d = cmd_frame;
            bit1_d  = cmd_frame[0];
            bit0_d  = ~cmd_frame[0];
            busy_d  = 1'b1;
            state_d = S_DRIVE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_DRIVE: begin
        bit0_d = bit0_q;
        bit1_d = bit1_q;
        if (ack_s) begin
          bit0_d  = 1'b0;
          bit1_d  = 1'b0;
          cnt_d   = '0;
          state_d = S_RTZ;
        end else if (cnt_end) begin
          bit0_d  = 1'b0;
          bit1_d  = 1'b0;
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_ABORT;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_RTZ: begin
        if (!ack_s) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            idx_d   = idx_nxt;
            bit1_d  = bit_nxt;
            bit0_d  = ~bit_nxt;
            state_d = S_DRIVE;
          end
        end else if (cnt_end) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = S_ABORT;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_ABORT: begin
        // A stuck-high ack still releases the sender after one more window.
        if (!ack_s || cnt_end) begin
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ack_sync_q <= '0;
      frame_q    <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      bit0_q     <= 1'b0;
      bit1_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ack_sync_q <= ack_sync_d;
      frame_q    <= frame_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      bit0_q     <= bit0_d;
      bit1_q     <= bit1_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bit0_out = bit0_q;
  assign bit1_out = bit1_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_channel_frame_sender.sv
// Scoreboard bench for channel_frame_sender.
// Far-end receiver echoes rails onto ack after a programmable delay.
module tb_channel_frame_sender;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic go = 1'b0;
  logic ch1 = 1'b0;
  logic ch2 = 1'b0;
  logic up = 1'b0;
  logic down = 1'b0;
  logic ack = 1'b0;
  logic bit0_out, bit1_out, busy, done, err;

  int tests_run = 0;
  int tests_failed = 0;

  bit exp_q[$];
  bit obs_q[$];
  int done_cnt = 0;
  int err_cnt = 0;
  int both_hi = 0;
  int glitch = 0;
  int de_both = 0;
  int hi_len = 0;
  int last_hi_len = 0;
  logic p0 = 1'b0;
  logic p1 = 1'b0;

  int ack_mode = 1;
  int ack_dly = 0;
  logic [7:0] hist = '0;

  always #5 clk = ~clk;

  channel_frame_sender dut (
    .clk(clk),
    .reset(reset),
    .go(go),
    .ch1(ch1),
    .ch2(ch2),
    .up(up),
    .down(down),
    .ack(ack),
    .bit0_out(bit0_out),
    .bit1_out(bit1_out),
    .busy(busy),
    .done(done),
    .err(err)
  );

  always @(negedge clk) begin
    if (bit0_out && bit1_out) both_hi++;
    if ((bit0_out | bit1_out) && (p0 | p1) &&
        ({bit1_out, bit0_out} != {p1, p0})) glitch++;
    if ((bit0_out | bit1_out) && !(p0 | p1)) obs_q.push_back(bit1_out);
    if (bit0_out | bit1_out) hi_len++;
    else begin
      if (hi_len != 0) last_hi_len = hi_len;
      hi_len = 0;
    end
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (done && err) de_both++;
    p0 = bit0_out;
    p1 = bit1_out;
  end

  always @(negedge clk) begin
    hist = {hist[6:0], bit0_out | bit1_out};
    ack = (ack_mode != 0) ? hist[ack_dly] : 1'b0;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic clear_sb();
    @(posedge clk);
    #1;
    exp_q.delete();
    obs_q.delete();
    done_cnt = 0;
    err_cnt = 0;
    both_hi = 0;
    glitch = 0;
    de_both = 0;
    last_hi_len = 0;
  endtask

  task automatic push_exp(input bit c2, input bit u);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    exp_q.push_back(c2);
    exp_q.push_back(u);
    exp_q.push_back(c2 ^ u);
  endtask

  task automatic pulse_go(input bit c1, input bit c2,
                          input bit u, input bit d);
    @(posedge clk);
    #1;
    ch1 = c1;
    ch2 = c2;
    up = u;
    down = d;
    go = 1'b1;
    @(posedge clk);
    #1;
    go = 1'b0;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({bit0_out, bit1_out, busy, done, err} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_outs: got %b want 00000",
               {bit0_out, bit1_out, busy, done, err});
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({bit0_out, bit1_out, busy, done, err} !== 5'b0) begin
      tests_failed++;
      $display("FAIL idle_outs: got %b want 00000",
               {bit0_out, bit1_out, busy, done, err});
    end
  endtask

  task automatic test_ch2_up();
    bit ok;
    bit o, e;
    ack_mode = 1;
    ack_dly = 0;
    clear_sb();
    push_exp(1'b1, 1'b1);
    pulse_go(1'b0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    tests_run++;
    if ({busy, bit1_out, bit0_out} !== 3'b110) begin
      tests_failed++;
      $display("FAIL t1_first_rail: busy/b1/b0 got %b want 110",
               {busy, bit1_out, bit0_out});
    end
    wait_idle(2000, ok);
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL t1_idle: busy stuck got 1 want 0");
    end
    tests_run++;
    if (obs_q.size() != 5) begin
      tests_failed++;
      $display("FAIL t1_nbits: got %0d want 5", obs_q.size());
    end
    for (int i = 0; i < 5 && obs_q.size() > 0 && exp_q.size() > 0; i++) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL t1_bit%0d: got %0b want %0b", i, o, e);
      end
    end
    tests_run++;
    if (done_cnt != 1 || err_cnt != 0) begin
      tests_failed++;
      $display("FAIL t1_pulses: done %0d err %0d want 1 0",
               done_cnt, err_cnt);
    end
    tests_run++;
    if (both_hi != 0 || glitch != 0 || de_both != 0) begin
      tests_failed++;
      $display("FAIL t1_rails: both %0d glitch %0d de %0d want 0",
               both_hi, glitch, de_both);
    end
  endtask

  task automatic test_ch1_down_slow();
    bit ok;
    bit o, e;
    ack_mode = 1;
    ack_dly = 3;
    clear_sb();
    push_exp(1'b0, 1'b0);
    pulse_go(1'b1, 1'b0, 1'b0, 1'b1);
    wait_idle(2000, ok);
    tests_run++;
    if (!ok || obs_q.size() != 5) begin
      tests_failed++;
      $display("FAIL t2_frame: idle %0b nbits %0d want 1 5",
               ok, obs_q.size());
    end
    for (int i = 0; i < 5 && obs_q.size() > 0 && exp_q.size() > 0; i++) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL t2_bit%0d: got %0b want %0b", i, o, e);
      end
    end
    tests_run++;
    if (done_cnt != 1 || err_cnt != 0 || both_hi != 0 || glitch != 0) begin
      tests_failed++;
      $display("FAIL t2_pulses: done %0d err %0d both %0d glitch %0d",
               done_cnt, err_cnt, both_hi, glitch);
    end
  endtask

  task automatic test_invalid();
    logic [3:0] tbl [4];
    tbl[0] = 4'b1110;
    tbl[1] = 4'b0010;
    tbl[2] = 4'b1011;
    tbl[3] = 4'b0000;
    ack_mode = 1;
    ack_dly = 0;
    for (int k = 0; k < 4; k++) begin
      clear_sb();
      pulse_go(tbl[k][3], tbl[k][2], tbl[k][1], tbl[k][0]);
      @(negedge clk);
      tests_run++;
      if ({err, busy, bit1_out, bit0_out} !== 4'b1000) begin
        tests_failed++;
        $display("FAIL t3_err_%0d: err/busy/b1/b0 got %b want 1000",
                 k, {err, busy, bit1_out, bit0_out});
      end
      repeat (3) @(negedge clk);
      tests_run++;
      if (err_cnt != 1 || obs_q.size() != 0 || busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL t3_after_%0d: errs %0d rails %0d busy %0b want 1 0 0",
                 k, err_cnt, obs_q.size(), busy);
      end
    end
  endtask

  task automatic test_timeout();
    bit seen;
    ack_mode = 0;
    clear_sb();
    push_exp(1'b0, 1'b1);
    pulse_go(1'b1, 1'b0, 1'b1, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (err) begin
        seen = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL t4_err_seen: got 0 want 1");
    end
    tests_run++;
    if ({busy, bit1_out, bit0_out} !== 3'b100) begin
      tests_failed++;
      $display("FAIL t4_abort: busy/b1/b0 got %b want 100",
               {busy, bit1_out, bit0_out});
    end
    @(negedge clk);
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL t4_release: busy got %b want 0", busy);
    end
    repeat (3) @(negedge clk);
    tests_run++;
    if (last_hi_len != 255) begin
      tests_failed++;
      $display("FAIL t4_hi_len: got %0d want 255", last_hi_len);
    end
    tests_run++;
    if (err_cnt != 1 || done_cnt != 0 || obs_q.size() != 1) begin
      tests_failed++;
      $display("FAIL t4_pulses: err %0d done %0d nbits %0d want 1 0 1",
               err_cnt, done_cnt, obs_q.size());
    end
    if (obs_q.size() > 0) begin
      tests_run++;
      if (obs_q[0] !== exp_q[0]) begin
        tests_failed++;
        $display("FAIL t4_bit0: got %0b want %0b", obs_q[0], exp_q[0]);
      end
    end
    ack_mode = 1;
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit o, e;
    ack_mode = 1;
    ack_dly = 2;
    clear_sb();
    push_exp(1'b1, 1'b0);
    pulse_go(1'b0, 1'b1, 1'b0, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (obs_q.size() == 3) begin
        ok = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL t5_third_bit: nbits %0d want 3", obs_q.size());
    end
    for (int i = 0; i < 3 && obs_q.size() > 0; i++) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL t5_pre_bit%0d: got %0b want %0b", i, o, e);
      end
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({busy, bit1_out, bit0_out, done, err} !== 5'b0) begin
      tests_failed++;
      $display("FAIL t5_reset: busy/b1/b0/done/err got %b want 00000",
               {busy, bit1_out, bit0_out, done, err});
    end
    reset = 1'b0;
    repeat (6) @(negedge clk);
    tests_run++;
    if (done_cnt != 0 || err_cnt != 0 || obs_q.size() != 0) begin
      tests_failed++;
      $display("FAIL t5_quiet: done %0d err %0d nbits %0d want 0 0 0",
               done_cnt, err_cnt, obs_q.size());
    end
    clear_sb();
    push_exp(1'b1, 1'b0);
    pulse_go(1'b0, 1'b1, 1'b0, 1'b1);
    wait_idle(2000, ok);
    tests_run++;
    if (!ok || obs_q.size() != 5 || done_cnt != 1) begin
      tests_failed++;
      $display("FAIL t5_refresh: idle %0b nbits %0d done %0d want 1 5 1",
               ok, obs_q.size(), done_cnt);
    end
    for (int i = 0; i < 5 && obs_q.size() > 0 && exp_q.size() > 0; i++) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL t5_bit%0d: got %0b want %0b", i, o, e);
      end
    end
  endtask

  task automatic test_go_mid();
    bit ok;
    bit o, e;
    ack_mode = 1;
    ack_dly = 1;
    clear_sb();
    push_exp(1'b0, 1'b1);
    pulse_go(1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (obs_q.size() >= 2) break;
    end
    pulse_go(1'b0, 1'b1, 1'b0, 1'b1);
    wait_idle(2000, ok);
    tests_run++;
    if (!ok || obs_q.size() != 5) begin
      tests_failed++;
      $display("FAIL t6_frame: idle %0b nbits %0d want 1 5",
               ok, obs_q.size());
    end
    for (int i = 0; i < 5 && obs_q.size() > 0 && exp_q.size() > 0; i++) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL t6_bit%0d: got %0b want %0b", i, o, e);
      end
    end
    tests_run++;
    if (done_cnt != 1 || err_cnt != 0) begin
      tests_failed++;
      $display("FAIL t6_pulses: done %0d err %0d want 1 0",
               done_cnt, err_cnt);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit o, e;
    bit c2, u;
    int nb;
    ack_mode = 1;
    ack_dly = 0;
    clear_sb();
    for (int k = 0; k < 4; k++) begin
      c2 = (k & 2) != 0;
      u = (k & 1) != 0;
      push_exp(c2, u);
      pulse_go(~c2, c2, u, ~u);
      wait_idle(2000, ok);
      tests_run++;
      if (!ok) begin
        tests_failed++;
        $display("FAIL b2b_idle%0d: busy got 1 want 0", k);
      end
    end
    nb = obs_q.size();
    tests_run++;
    if (nb != 20) begin
      tests_failed++;
      $display("FAIL b2b_nbits: got %0d want 20", nb);
    end
    for (int i = 0; i < 20 && obs_q.size() > 0 && exp_q.size() > 0; i++) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL b2b_bit%0d: got %0b want %0b", i, o, e);
      end
    end
    tests_run++;
    if (done_cnt != 4 || err_cnt != 0 || both_hi != 0 ||
        glitch != 0 || de_both != 0) begin
      tests_failed++;
      $display("FAIL b2b_pulses: done %0d err %0d both %0d glitch %0d de %0d",
               done_cnt, err_cnt, both_hi, glitch, de_both);
    end
  endtask

  initial begin
    test_reset();
    test_ch2_up();
    test_ch1_down_slow();
    test_invalid();
    test_timeout();
    test_reset_mid();
    test_go_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
